// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_gnt,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_gnt,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);
  localparam logic       OWNER_INST   = 1'b0;
  localparam logic       OWNER_DATA   = 1'b1;

  state_e     state_q, state_d;
  logic       started_q, started_d;
  logic       owner_q, owner_d;
  logic [3:0] streak_q, streak_d;

  logic is_idle;
  logic sel_data;
  logic grant;
  logic resp;

  // Request selection, memory-side mux and grants; data wins unless fetch has waited too long
  always_comb begin
    is_idle   = (state_q == IDLE);
    sel_data  = data_req & (~inst_req | (streak_q < STREAK_LIMIT));
    mem_req   = is_idle & started_q & (inst_req | data_req);
    grant     = mem_req & mem_ready;
    inst_gnt  = grant & ~sel_data;
    data_gnt  = grant & sel_data;
    mem_addr  = sel_data ? data_addr : inst_addr;
    mem_wdata = data_wdata;
    mem_we    = mem_req & sel_data & data_we;
    mem_wstrb = (mem_req & sel_data) ? data_wstrb : '0;
    busy      = ~is_idle;
  end

  // Response routing to whichever requester owns the outstanding transaction
  always_comb begin
    resp       = ~is_idle & mem_rvalid;
    inst_valid = resp & (owner_q == OWNER_INST);
    data_valid = resp & (owner_q == OWNER_DATA);
    inst_rdata = mem_rdata;
    data_rdata = mem_rdata;
  end

  // Next-state logic: FSM, start latch, owner capture and data streak counter
  always_comb begin
    state_d   = state_q;
    started_d = started_q | start;
    owner_d   = owner_q;
    streak_d  = streak_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (inst_gnt) begin
      owner_d  = OWNER_INST;
      streak_d = 4'd0;
    end else if (data_gnt) begin
      owner_d = OWNER_DATA;
      if (inst_req) begin
        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      owner_q   <= OWNER_INST;
      streak_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic [31:0] INST_ADDR = 32'h0000_0100;
  localparam logic [31:0] DATA_ADDR = 32'h0000_2000;
  localparam logic [31:0] WDATA     = 32'hDEAD_BEEF;
  localparam logic [3:0]  WSTRB     = 4'h3;
  localparam logic [31:0] RDATA     = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = INST_ADDR;
  logic        inst_gnt, inst_valid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = DATA_ADDR;
  logic [31:0] data_wdata = WDATA;
  logic [3:0]  data_wstrb = WSTRB;
  logic        data_gnt, data_valid;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = RDATA;
  logic        busy;

  int applied = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_gnt(data_gnt),
    .data_valid(data_valid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // inputs: rst_n start inst_req data_req data_we mem_ready mem_rvalid
  // exp   : {mem_req, inst_gnt, data_gnt, inst_valid, data_valid, busy, mem_we}
  typedef struct {
    string      name;
    logic [6:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [6:0] in, input logic [6:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {mem_req, inst_gnt, data_gnt, inst_valid, data_valid, busy, mem_we};
  endfunction

  initial begin
    //                           rst st ir dr we rdy rv        mreq ig dg iv dv bsy we
    add("reset",               7'b0_0_0_0_0_0_0, 7'b0_0_0_0_0_0_0);
    for (int i = 0; i < 5; i++)
      add("gate_no_start",     7'b1_0_1_0_0_1_0, 7'b0_0_0_0_0_0_0);
    add("start_rise_cycle",    7'b1_1_1_0_0_1_0, 7'b0_0_0_0_0_0_0);
    add("fetch_grant",         7'b1_0_1_0_0_1_0, 7'b1_1_0_0_0_0_0);
    add("fetch_resp",          7'b1_0_0_0_0_0_1, 7'b0_0_0_1_0_1_0);
    add("idle_after_fetch",    7'b1_0_0_0_0_0_0, 7'b0_0_0_0_0_0_0);
    add("prio_data_first",     7'b1_0_1_1_0_1_0, 7'b1_0_1_0_0_0_0);
    add("prio_data_resp",      7'b1_0_1_0_0_1_1, 7'b0_0_0_0_1_1_0);
    add("prio_inst_next",      7'b1_0_1_0_0_1_0, 7'b1_1_0_0_0_0_0);
    add("prio_inst_resp",      7'b1_0_0_0_0_1_1, 7'b0_0_0_1_0_1_0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        add("starve_D_grant",  7'b1_0_1_1_0_1_0, 7'b1_0_1_0_0_0_0);
        add("starve_D_resp",   7'b1_0_1_1_0_1_1, 7'b0_0_0_0_1_1_0);
      end
      add("starve_I_grant",    7'b1_0_1_1_0_1_0, 7'b1_1_0_0_0_0_0);
      add("starve_I_resp",     7'b1_0_1_1_0_1_1, 7'b0_0_0_1_0_1_0);
    end
    add("not_ready_hold",      7'b1_0_1_1_0_0_0, 7'b1_0_0_0_0_0_0);
    add("store_grant",         7'b1_0_0_1_1_1_0, 7'b1_0_1_0_0_0_1);
    add("store_ack",           7'b1_0_0_0_0_0_1, 7'b0_0_0_0_1_1_0);
    add("spurious_rvalid",     7'b1_0_0_0_0_0_1, 7'b0_0_0_0_0_0_0);
    add("rst_pre_grant",       7'b1_0_1_0_0_1_0, 7'b1_1_0_0_0_0_0);
    add("rst_mid_flight",      7'b0_0_1_0_0_1_0, 7'b0_0_0_0_0_0_0);
    add("late_rvalid_ignored", 7'b1_0_1_0_0_1_1, 7'b0_0_0_0_0_0_0);
    add("no_req_before_start", 7'b1_0_1_0_0_1_0, 7'b0_0_0_0_0_0_0);
    add("restart_rise",        7'b1_1_1_0_0_1_0, 7'b0_0_0_0_0_0_0);
    add("restart_grant",       7'b1_0_1_0_0_1_0, 7'b1_1_0_0_0_0_0);
    add("restart_resp",        7'b1_0_0_0_0_0_1, 7'b0_0_0_1_0_1_0);

    foreach (vecs[i]) begin
      logic [6:0] act;
      logic       ok;
      @(negedge clk);
      {rst_n, start, inst_req, data_req, data_we, mem_ready, mem_rvalid} = vecs[i].in;
      #1;
      act = outs();
      ok  = (act === vecs[i].exp);
      if (vecs[i].exp[5]) ok &= (mem_addr === INST_ADDR) && (mem_wstrb === 4'h0);
      if (vecs[i].exp[4]) ok &= (mem_addr === DATA_ADDR);
      if (vecs[i].exp[0]) ok &= (mem_wdata === WDATA) && (mem_wstrb === WSTRB);
      if (vecs[i].exp[3] | vecs[i].exp[2]) ok &= (inst_rdata === RDATA) && (data_rdata === RDATA);
      applied++;
      if (!ok) begin
        miscompares++;
        $display("FAIL vec %0d %s: outs=%b expected=%b addr=%h wdata=%h wstrb=%h irdata=%h drdata=%h",
                 i, vecs[i].name, act, vecs[i].exp, mem_addr, mem_wdata, mem_wstrb, inst_rdata, data_rdata);
      end
    end

    // Hand sequence: memory latency of 3 cycles keeps busy up and suppresses new requests
    @(negedge clk);
    {start, inst_req, data_req, data_we, mem_ready, mem_rvalid} = 6'b0_1_0_0_1_0;
    #1 check("lat3_grant", {60'd0, mem_req, inst_gnt, data_gnt, busy}, {60'd0, 4'b1100});
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      {inst_req, data_req, mem_rvalid} = 3'b110;
      #1 check("lat3_wait", {59'd0, mem_req, inst_gnt, data_gnt, busy, inst_valid}, {59'd0, 5'b00010});
    end
    @(negedge clk);
    {inst_req, data_req, mem_rvalid} = 3'b001;
    #1 check("lat3_resp", {60'd0, inst_valid, data_valid, busy, mem_req}, {60'd0, 4'b1010});

    // Hand sequence: mem_ready low keeps IDLE and selection follows requester changes
    @(negedge clk);
    {inst_req, data_req, data_we, mem_ready, mem_rvalid} = 5'b10000;
    #1 check("nordy_inst_addr", {mem_addr, 28'd0, mem_req, inst_gnt, data_gnt, busy},
                                {INST_ADDR, 28'd0, 4'b1000});
    @(negedge clk);
    {inst_req, data_req, data_we} = 3'b111;
    #1 check("nordy_data_addr", {mem_addr, 28'd0, mem_req, mem_we, data_gnt, busy},
                                {DATA_ADDR, 28'd0, 4'b1100});
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("nordy_then_grant", {60'd0, data_gnt, inst_gnt, mem_we, busy}, {60'd0, 4'b1010});
    @(negedge clk);
    {inst_req, data_req, data_we, mem_ready, mem_rvalid} = 5'b00001;
    #1 check("nordy_store_ack", {60'd0, data_valid, inst_valid, busy, mem_req}, {60'd0, 4'b1010});
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 check("final_idle", {61'd0, busy, mem_req, mem_we}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester. Sits between the core pipeline and the chip memory; it gates all traffic until `start` is seen after reset, issues one outstanding transaction at a time, and routes each response back to its owner as the `inst_valid`/`data_valid` pulses visible at chip level. Data accesses have priority, bounded by a starvation limit so fetch always progresses.

## Interface
- `ADDR_WIDTH`, 32: address width, both requesters and memory.
- `DATA_WIDTH`, 32: data width; `DATA_WIDTH/8` byte strobes.
- `MAX_DATA_STREAK`, 4: consecutive data grants allowed while `inst_req` waits (legal range 1..15).
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: enable. Sampled each cycle; once seen high it is latched until reset.
- `inst_req` in 1: fetch request, level, held until granted.
- `inst_addr` in ADDR_WIDTH: fetch address.
- `inst_gnt` out 1: fetch request accepted this cycle.
- `inst_valid` out 1: one-cycle fetch response pulse.
- `inst_rdata` out DATA_WIDTH: fetch data, valid with `inst_valid`.
- `data_req` in 1: load/store request, level, held until granted.
- `data_we` in 1: 1 = store, 0 = load.
- `data_addr` in ADDR_WIDTH: load/store address.
- `data_wdata` in DATA_WIDTH: store data.
- `data_wstrb` in DATA_WIDTH/8: store byte enables.
- `data_gnt` out 1: load/store request accepted this cycle.
- `data_valid` out 1: one-cycle response pulse for a load, or the ack for a store.
- `data_rdata` out DATA_WIDTH: load data, valid with `data_valid`. Don't-care for stores.
- `mem_req` out 1: memory request.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out: muxed from the selected requester. `mem_we`=0 and `mem_wstrb`=0 when the instruction side is selected.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: memory response or store ack (exactly one per accepted request).
- `mem_rdata` in DATA_WIDTH: memory read data.
- `busy` out 1: a transaction is outstanding.

## Operation
- `started` flag:
  - Cleared by reset.
  - Set on the first cycle `start`=1.
  - `mem_req` is forced 0 while `started`=0 (the cycle `start` first rises is included).
- FSM states:
  - IDLE to WAIT_RESP when `mem_req & mem_ready`.
  - WAIT_RESP to IDLE when `mem_rvalid`.
- Output behaviour by state:
  - In IDLE, `mem_req = started & (inst_req | data_req)`.
  - In WAIT_RESP, `mem_req`=0 and `busy`=1.
- Selection (combinational, IDLE only):
  - Only one requesting: that one is selected.
  - Both requesting: data wins unless `streak` ≥ MAX_DATA_STREAK; then inst wins.
- Grants:
  - `inst_gnt`/`data_gnt` = `mem_req & mem_ready & selected`.
  - At most one grant per cycle.
  - On a grant, `owner` (inst/data) is registered.
- `streak` counter (4 bits):
  - Increments on a data grant made while `inst_req`=1; saturates at 15.
  - Clears on any inst grant, or on a data grant with `inst_req`=0.
- Response routing:
  - In WAIT_RESP, `mem_rvalid` produces `inst_valid` or `data_valid` for `owner` in the same cycle.
  - `mem_rdata` is passed through combinationally to both rdata outputs.
  - Valid outputs are 0 otherwise.
- Ignored inputs: `mem_rvalid` in IDLE (spurious), and requester inputs during WAIT_RESP (requesters keep holding).
- Reset values: state=IDLE, `started`=0, `owner`=inst, `streak`=0. All outputs are 0: `mem_req`, both gnts, both valids, `busy`, `mem_we`, `mem_wstrb`.

## Timing
- Minimum transaction: grant in cycle N, `mem_rvalid` no earlier than N+1, response pulse in the same cycle as `mem_rvalid`.
- Next request: IDLE resumes in cycle N+k+1 (k = memory latency), so a new request is possible then. Peak rate is 1 transaction per 2 cycles.
- Simultaneous `mem_rvalid` and a new request: the new request is not issued until the following cycle (no back-to-back overlap).
- `mem_ready`=0 in IDLE: remain in IDLE, no grant, selection re-evaluated each cycle. The mem_* outputs may change only if requester inputs change.
- Reset mid-transaction: immediate return to IDLE with `started`=0. A late `mem_rvalid` after reset is ignored. `start` must be seen again before any request.

## Test plan
- Start gating:
  - Drive `inst_req`=1 with `start`=0 for 5 cycles: `mem_req` stays 0.
  - Raise `start`: `mem_req`=1 the next cycle.
- Single fetch:
  - `mem_ready`=1, `inst_addr`=0x100, `mem_rvalid` one cycle after grant with `mem_rdata`=0x00500093.
  - Expect `inst_gnt` 1 cycle, `inst_valid`=1 with `inst_rdata`=0x00500093, `busy` high exactly 1 cycle.
- Priority:
  - Both requests together, `data_addr`=0x2000, load.
  - Expect `data_gnt` first, `mem_addr`=0x2000, `mem_we`=0; `inst_gnt` after `data_valid`.
- Starvation bound:
  - `inst_req` and `data_req` held high with MAX_DATA_STREAK=4.
  - Grant order: D,D,D,D,I,D,D,D,D,I; `streak` never exceeds 4.
- Store:
  - `data_we`=1, `data_wdata`=0xDEADBEEF, `data_wstrb`=0x3.
  - Expect mem_* to mirror these values; `data_valid` on the ack; `inst_valid` stays 0.
- Reset mid-flight:
  - Assert `rst_n`=0 while in WAIT_RESP, then release, then pulse `mem_rvalid`.
  - Expect no valid output, `busy`=0, and no `mem_req` until `start`=1.
